// File: rtl/dma_cmd_sequencer.sv
// Queues DMA transfer descriptors and issues them one at a time over the load/ACK/start/INT handshake.
// Define DMA_TIMEOUT_EN to add a watchdog on the ACK and INT waits that drops the stuck descriptor and sets err.
module dma_cmd_sequencer #(
   parameter int FIFO_DEPTH     = 4,
   parameter int CNT_W          = 8,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        desc_valid,
   output logic                        desc_ready,
   input  logic [9:0]                  desc_origin,
   input  logic [9:0]                  desc_dest,
   input  logic [4:0]                  desc_bytes,
   output logic [9:0]                  OriginAddress,
   output logic [9:0]                  DestinationAddress,
   output logic [4:0]                  BytesQuantity,
   output logic                        load,
   output logic                        start,
   input  logic                        ACK,
   input  logic                        INT,
   output logic                        busy,
   output logic                        done_pulse,
   output logic                        skip_pulse,
   output logic [CNT_W-1:0]            done_count,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        err,
   input  logic                        err_clr
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_ACK,
      START,
      WAIT_INT,
      WAIT_LOW
   } state_t;

   state_t state;
   state_t next_state;

   logic [9:0] fifo_origin [FIFO_DEPTH];
   logic [9:0] fifo_dest   [FIFO_DEPTH];
   logic [4:0] fifo_bytes  [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level_next;
   logic             fifo_empty;
   logic             fifo_full;
   logic             push;
   logic             pop;
   logic             issue;
   logic             skip;
   logic             done;
   logic             timeout;
   logic             tmo_hit;

   assign fifo_empty = (fifo_level == '0);
   assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
   assign desc_ready = !fifo_full;
   assign push       = desc_valid && !fifo_full;

   // Descriptor storage carries no reset; only the pointers and level define its contents.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_origin[wr_ptr] <= desc_origin;
         fifo_dest[wr_ptr]   <= desc_dest;
         fifo_bytes[wr_ptr]  <= desc_bytes;
      end
   end

   always_comb begin
      level_next = fifo_level;
      if (push && !pop) begin
         level_next = fifo_level + LVL_W'(1);
      end else if (pop && !push) begin
         level_next = fifo_level - LVL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fifo_level <= level_next;
      end
   end

   // The head entry stays queued while it is in flight and is popped only on completion, skip or timeout.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      issue      = 1'b0;
      skip       = 1'b0;
      done       = 1'b0;
      timeout    = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               if (fifo_bytes[rd_ptr] == 5'd0) begin
                  pop  = 1'b1;
                  skip = 1'b1;
               end else begin
                  issue      = 1'b1;
                  next_state = LOAD;
               end
            end
         end
         LOAD: next_state = WAIT_ACK;
         WAIT_ACK: begin
            if (ACK) begin
               next_state = START;
            end else if (tmo_hit) begin
               pop        = 1'b1;
               timeout    = 1'b1;
               next_state = WAIT_LOW;
            end
         end
         START: next_state = WAIT_INT;
         WAIT_INT: begin
            if (INT) begin
               pop        = 1'b1;
               done       = 1'b1;
               next_state = WAIT_LOW;
            end else if (tmo_hit) begin
               pop        = 1'b1;
               timeout    = 1'b1;
               next_state = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            if (!INT) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Every DMA-facing output is a flop so the controller never sees a combinational path from ACK/INT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state              <= IDLE;
         load               <= 1'b0;
         start              <= 1'b0;
         busy               <= 1'b0;
         done_pulse         <= 1'b0;
         skip_pulse         <= 1'b0;
         done_count         <= '0;
         OriginAddress      <= '0;
         DestinationAddress <= '0;
         BytesQuantity      <= '0;
      end else begin
         state      <= next_state;
         load       <= (next_state == LOAD);
         start      <= (next_state == START);
         busy       <= (next_state != IDLE) || (level_next != '0);
         done_pulse <= done;
         skip_pulse <= skip;
         if (done) begin
            done_count <= done_count + 1'b1;
         end
         if (issue) begin
            OriginAddress      <= fifo_origin[rd_ptr];
            DestinationAddress <= fifo_dest[rd_ptr];
            BytesQuantity      <= fifo_bytes[rd_ptr];
         end
      end
   end

`ifdef DMA_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt;

   assign tmo_hit = ((state == WAIT_ACK) || (state == WAIT_INT)) &&
                    (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   // Counts cycles spent in the current wait state and restarts on every state change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
      end else if (next_state != state) begin
         tmo_cnt <= '0;
      end else if ((state == WAIT_ACK) || (state == WAIT_INT)) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   // A timeout in the same cycle as err_clr leaves err set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else if (timeout) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end
   end
`else
   logic unused_cfg;

   assign tmo_hit    = 1'b0;
   assign err        = 1'b0;
   assign unused_cfg = ^{err_clr, timeout, TIMEOUT_CYCLES};
`endif

endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// Self-checking bench for dma_cmd_sequencer: a behavioural DMA responder plus a descriptor-order model.
// Covers the timeout path when DMA_TIMEOUT_EN is defined, otherwise checks that err never rises.
module tb_dma_cmd_sequencer;
   localparam int FIFO_DEPTH     = 4;
   localparam int CNT_W          = 8;
   localparam int TIMEOUT_CYCLES = 16;
   localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             desc_valid;
   logic             desc_ready;
   logic [9:0]       desc_origin;
   logic [9:0]       desc_dest;
   logic [4:0]       desc_bytes;
   logic [9:0]       OriginAddress;
   logic [9:0]       DestinationAddress;
   logic [4:0]       BytesQuantity;
   logic             load;
   logic             start;
   logic             ACK;
   logic             INT;
   logic             busy;
   logic             done_pulse;
   logic             skip_pulse;
   logic [CNT_W-1:0] done_count;
   logic [LVL_W-1:0] fifo_level;
   logic             err;
   logic             err_clr;

   int checks   = 0;
   int failures = 0;

   // Model: every non-zero descriptor is issued in push order; zero-length ones are only skipped.
   logic [24:0] exp_q[$];
   logic [24:0] obs_q[$];
   int exp_done_total = 0;
   int exp_skip       = 0;

   int load_seen      = 0;
   int start_seen     = 0;
   int done_seen      = 0;
   int skip_seen      = 0;
   int load_while_int = 0;
   int err_seen       = 0;

   bit rsp_en     = 1'b1;
   bit rsp_random = 1'b0;
   bit rsp_abort  = 1'b0;
   bit rsp_active = 1'b0;
   int ack_dly    = 0;
   int int_dly    = 0;
   int int_hold   = 1;

   dma_cmd_sequencer #(
      .FIFO_DEPTH    (FIFO_DEPTH),
      .CNT_W         (CNT_W),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .desc_valid        (desc_valid),
      .desc_ready        (desc_ready),
      .desc_origin       (desc_origin),
      .desc_dest         (desc_dest),
      .desc_bytes        (desc_bytes),
      .OriginAddress     (OriginAddress),
      .DestinationAddress(DestinationAddress),
      .BytesQuantity     (BytesQuantity),
      .load              (load),
      .start             (start),
      .ACK               (ACK),
      .INT               (INT),
      .busy              (busy),
      .done_pulse        (done_pulse),
      .skip_pulse        (skip_pulse),
      .done_count        (done_count),
      .fifo_level        (fifo_level),
      .err               (err),
      .err_clr           (err_clr)
   );

   always #5 clk = ~clk;

   // Observes the DMA side on the falling edge and logs every issued descriptor.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (load === 1'b1) begin
            obs_q.push_back({OriginAddress, DestinationAddress, BytesQuantity});
            load_seen++;
            if (INT === 1'b1) load_while_int++;
         end
         if (start === 1'b1) start_seen++;
         if (done_pulse === 1'b1) done_seen++;
         if (skip_pulse === 1'b1) skip_seen++;
         if (err === 1'b1) err_seen++;
      end
   end

   // Behavioural DMA: ACK some cycles after load, INT some cycles after start, INT released after done.
   initial begin : responder
      int a;
      int di;
      int h;
      int n;
      ACK = 1'b0;
      INT = 1'b0;
      forever begin
         @(negedge clk);
         if (load === 1'b1 && rsp_en && !rsp_abort) begin
            rsp_active = 1'b1;
            if (rsp_random) begin
               a  = $urandom_range(0, 4);
               di = $urandom_range(0, 6);
               h  = $urandom_range(0, 4);
            end else begin
               a  = ack_dly;
               di = int_dly;
               h  = int_hold;
            end
            for (int i = 0; i < a && !rsp_abort; i++) @(negedge clk);
            if (!rsp_abort) ACK = 1'b1;
            n = 0;
            while (start !== 1'b1 && !rsp_abort && n < 500) begin
               @(negedge clk);
               n++;
            end
            ACK = 1'b0;
            for (int i = 0; i < di && !rsp_abort; i++) @(negedge clk);
            if (!rsp_abort) INT = 1'b1;
            n = 0;
            while (done_pulse !== 1'b1 && !rsp_abort && n < 500) begin
               @(negedge clk);
               n++;
            end
            for (int i = 0; i < h && !rsp_abort; i++) @(negedge clk);
            INT        = 1'b0;
            rsp_active = 1'b0;
         end
      end
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog sim_time=%0t required=finish_earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic push_desc(input logic [9:0] o, input logic [9:0] d, input logic [4:0] b);
      int waited = 0;
      desc_origin = o;
      desc_dest   = d;
      desc_bytes  = b;
      desc_valid  = 1'b1;
      while (desc_ready !== 1'b1 && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (desc_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL push_accept desc_ready=%b required=1", desc_ready);
      end else if (b == 5'd0) begin
         exp_skip++;
      end else begin
         exp_q.push_back({o, d, b});
         exp_done_total++;
      end
      @(negedge clk);
      desc_valid = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      int n = 0;
      @(negedge clk);
      while (!(busy === 1'b0 && !rsp_active && INT === 1'b0) && n < 6000) begin
         @(negedge clk);
         n++;
      end
      ok = (busy === 1'b0) && !rsp_active;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({load, start, busy, done_pulse, skip_pulse, err, OriginAddress, DestinationAddress,
           BytesQuantity, done_count, fifo_level} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_outputs got=%h required=0", {load, start, busy, done_pulse,
                  skip_pulse, err, OriginAddress, DestinationAddress, BytesQuantity, done_count, fifo_level});
      end
      checks++;
      if (desc_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_ready got=%b required=1", desc_ready);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      int l0 = load_seen;
      int s0 = start_seen;
      int d0 = done_seen;
      bit ok;
      logic [24:0] e;
      logic [24:0] o;
      rsp_random = 1'b0;
      ack_dly    = 2;
      int_dly    = 10;
      int_hold   = 1;
      push_desc(10'h010, 10'h200, 5'd8);
      wait_idle(ok);
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL single_idle busy=%b required=0", busy); end
      checks++;
      if (load_seen - l0 != 1) begin failures++; $display("[TB] FAIL single_loads got=%0d required=1", load_seen - l0); end
      checks++;
      if (start_seen - s0 != 1) begin failures++; $display("[TB] FAIL single_starts got=%0d required=1", start_seen - s0); end
      checks++;
      if (done_seen - d0 != 1) begin failures++; $display("[TB] FAIL single_dones got=%0d required=1", done_seen - d0); end
      checks++;
      if (done_count !== CNT_W'(exp_done_total)) begin
         failures++;
         $display("[TB] FAIL single_count got=%0d required=%0d", done_count, CNT_W'(exp_done_total));
      end
      checks++;
      if ({OriginAddress, DestinationAddress, BytesQuantity} !== {10'h010, 10'h200, 5'd8}) begin
         failures++;
         $display("[TB] FAIL single_held got=%h/%h/%0d required=010/200/8", OriginAddress, DestinationAddress, BytesQuantity);
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("[TB] FAIL single_order got=%h required=%h", o, e); end
      end
   endtask

   task automatic test_fill();
      bit ok;
      logic [24:0] e;
      logic [24:0] o;
      rsp_random = 1'b0;
      ack_dly    = 3;
      int_dly    = 2;
      int_hold   = 1;
      for (int i = 0; i < 4; i++) begin
         push_desc(10'($urandom), 10'($urandom), 5'($urandom_range(1, 31)));
      end
      checks++;
      if (desc_ready !== 1'b0) begin failures++; $display("[TB] FAIL fill_ready got=%b required=0", desc_ready); end
      checks++;
      if (fifo_level !== LVL_W'(4)) begin failures++; $display("[TB] FAIL fill_level got=%0d required=4", fifo_level); end
      wait_idle(ok);
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL fill_idle busy=%b required=0", busy); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("[TB] FAIL fill_order got=%h required=%h", o, e); end
      end
      checks++;
      if (done_count !== CNT_W'(exp_done_total)) begin
         failures++;
         $display("[TB] FAIL fill_count got=%0d required=%0d", done_count, CNT_W'(exp_done_total));
      end
   endtask

   task automatic test_skip();
      int l0 = load_seen;
      int k0 = skip_seen;
      int d0 = done_seen;
      bit ok;
      logic [24:0] e;
      logic [24:0] o;
      rsp_random = 1'b0;
      ack_dly    = 0;
      int_dly    = 0;
      int_hold   = 1;
      push_desc(10'h000, 10'h100, 5'd0);
      push_desc(10'h005, 10'h105, 5'd3);
      wait_idle(ok);
      checks++;
      if (skip_seen - k0 != 1) begin failures++; $display("[TB] FAIL skip_pulses got=%0d required=1", skip_seen - k0); end
      checks++;
      if (load_seen - l0 != 1) begin failures++; $display("[TB] FAIL skip_loads got=%0d required=1", load_seen - l0); end
      checks++;
      if (done_seen - d0 != 1) begin failures++; $display("[TB] FAIL skip_dones got=%0d required=1", done_seen - d0); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("[TB] FAIL skip_order got=%h required=%h", o, e); end
      end
   endtask

   task automatic test_int_held();
      int l0 = load_seen;
      int d0 = done_seen;
      int w0 = load_while_int;
      bit ok;
      rsp_random = 1'b0;
      ack_dly    = 0;
      int_dly    = 0;
      int_hold   = 20;
      push_desc(10'h123, 10'h321, 5'd4);
      push_desc(10'h0F0, 10'h30F, 5'd9);
      wait_idle(ok);
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL held_idle busy=%b required=0", busy); end
      checks++;
      if (done_seen - d0 != 2) begin failures++; $display("[TB] FAIL held_dones got=%0d required=2", done_seen - d0); end
      checks++;
      if (load_seen - l0 != 2) begin failures++; $display("[TB] FAIL held_loads got=%0d required=2", load_seen - l0); end
      checks++;
      if (load_while_int != w0) begin failures++; $display("[TB] FAIL held_early_load got=%0d required=0", load_while_int - w0); end
      checks++;
      if (done_count !== CNT_W'(exp_done_total)) begin
         failures++;
         $display("[TB] FAIL held_count got=%0d required=%0d", done_count, CNT_W'(exp_done_total));
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset_mid();
      int s0 = start_seen;
      int n = 0;
      rsp_random = 1'b0;
      ack_dly    = 0;
      int_dly    = 40;
      int_hold   = 1;
      push_desc(10'h011, 10'h211, 5'd5);
      push_desc(10'h022, 10'h222, 5'd6);
      while (start_seen == s0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (fifo_level !== LVL_W'(2)) begin failures++; $display("[TB] FAIL rmid_level_before got=%0d required=2", fifo_level); end
      rst       = 1'b0;
      rsp_abort = 1'b1;
      #1;
      checks++;
      if (fifo_level !== '0) begin failures++; $display("[TB] FAIL rmid_level got=%0d required=0", fifo_level); end
      checks++;
      if ({load, start, busy} !== 3'b000) begin failures++; $display("[TB] FAIL rmid_ctrl got=%b required=000", {load, start, busy}); end
      checks++;
      if ({OriginAddress, DestinationAddress, BytesQuantity} !== '0) begin
         failures++;
         $display("[TB] FAIL rmid_addr got=%h required=0", {OriginAddress, DestinationAddress, BytesQuantity});
      end
      checks++;
      if (done_count !== '0) begin failures++; $display("[TB] FAIL rmid_count got=%0d required=0", done_count); end
      n = 0;
      while (rsp_active && n < 100) begin
         @(negedge clk);
         n++;
      end
      rsp_abort = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      obs_q.delete();
      exp_done_total = 0;
      @(negedge clk);
   endtask

`ifdef DMA_TIMEOUT_EN
   task automatic test_timeout();
      int d0 = done_seen;
      int n = 0;
      bit ok;
      logic [24:0] e;
      logic [24:0] o;
      rsp_en = 1'b0;
      push_desc(10'h0AA, 10'h155, 5'd7);
      exp_done_total--;
      while (load !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (TIMEOUT_CYCLES) @(negedge clk);
      checks++;
      if (err !== 1'b0) begin failures++; $display("[TB] FAIL tmo_early err=%b required=0", err); end
      @(negedge clk);
      checks++;
      if (err !== 1'b1) begin failures++; $display("[TB] FAIL tmo_err err=%b required=1", err); end
      checks++;
      if (fifo_level !== '0) begin failures++; $display("[TB] FAIL tmo_drop level=%0d required=0", fifo_level); end
      wait_idle(ok);
      repeat (4) @(negedge clk);
      checks++;
      if (done_seen != d0) begin failures++; $display("[TB] FAIL tmo_dones got=%0d required=0", done_seen - d0); end
      checks++;
      if (done_count !== CNT_W'(exp_done_total)) begin
         failures++;
         $display("[TB] FAIL tmo_count got=%0d required=%0d", done_count, CNT_W'(exp_done_total));
      end
      checks++;
      if (err !== 1'b1) begin failures++; $display("[TB] FAIL tmo_sticky err=%b required=1", err); end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) begin failures++; $display("[TB] FAIL tmo_clear err=%b required=0", err); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("[TB] FAIL tmo_order got=%h required=%h", o, e); end
      end
      rsp_en = 1'b1;
   endtask
`else
   task automatic test_no_timeout();
      int d0 = done_seen;
      int e0 = err_seen;
      bit ok;
      rsp_random = 1'b0;
      ack_dly    = 60;
      int_dly    = 0;
      int_hold   = 1;
      push_desc(10'h0AA, 10'h155, 5'd7);
      repeat (20) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      wait_idle(ok);
      checks++;
      if (err_seen != e0) begin failures++; $display("[TB] FAIL notmo_err cycles=%0d required=0", err_seen - e0); end
      checks++;
      if (done_seen - d0 != 1) begin failures++; $display("[TB] FAIL notmo_dones got=%0d required=1", done_seen - d0); end
      checks++;
      if (done_count !== CNT_W'(exp_done_total)) begin
         failures++;
         $display("[TB] FAIL notmo_count got=%0d required=%0d", done_count, CNT_W'(exp_done_total));
      end
      exp_q.delete();
      obs_q.delete();
   endtask
`endif

   task automatic test_random();
      int k0 = skip_seen;
      int s0 = exp_skip;
      int w0 = load_while_int;
      bit ok;
      logic [4:0] b;
      logic [24:0] e;
      logic [24:0] o;
      rsp_random = 1'b1;
      for (int i = 0; i < 400; i++) begin
         b = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         push_desc(10'($urandom), 10'($urandom), b);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle(ok);
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL rand_idle busy=%b required=0", busy); end
      checks++;
      if (skip_seen - k0 != exp_skip - s0) begin
         failures++;
         $display("[TB] FAIL rand_skips got=%0d required=%0d", skip_seen - k0, exp_skip - s0);
      end
      checks++;
      if (load_while_int != w0) begin failures++; $display("[TB] FAIL rand_early_load got=%0d required=0", load_while_int - w0); end
      checks++;
      if (done_count !== CNT_W'(exp_done_total)) begin
         failures++;
         $display("[TB] FAIL rand_count got=%0d required=%0d", done_count, CNT_W'(exp_done_total));
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("[TB] FAIL rand_order got=%h required=%h", o, e); end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL rand_extra_loads got=%0d required=0", obs_q.size()); end
   endtask

   initial begin
      desc_valid  = 1'b0;
      desc_origin = '0;
      desc_dest   = '0;
      desc_bytes  = '0;
      err_clr     = 1'b0;
      test_reset();
      test_single();
      test_fill();
      test_skip();
      test_int_held();
      test_reset_mid();
`ifdef DMA_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
